// File: rtl/vc_output_arbiter.sv
// Wormhole round-robin arbiter: one output link shared by N_VC flit sources, packet-atomic grants.
// Zero-latency combinational datapath; downstream ready_i is routed only to the granted source.
module vc_output_arbiter #(
  parameter int N_VC   = 4,
  parameter int FLIT_W = 34,
  parameter int VC_W   = 2
) (
  input  logic                   clk,
  input  logic                   arst,
  input  logic [N_VC-1:0]        valid_i,
  input  logic [N_VC*FLIT_W-1:0] fdata_i,
  output logic [N_VC-1:0]        ready_o,
  output logic [FLIT_W-1:0]      fdata_o,
  output logic                   valid_o,
  input  logic                   ready_i,
  output logic [VC_W-1:0]        vc_id_o,
  output logic                   busy_o,
  output logic                   err_o
);
  typedef enum logic [1:0] {S_IDLE, S_HOLD, S_LOCKED} state_t;

  state_t          r_state;
  logic [VC_W-1:0] r_gnt;
  logic [VC_W-1:0] r_rr_ptr;
  logic            r_err;

  logic [VC_W-1:0]   w_idx;
  logic [VC_W-1:0]   w_pick;
  logic [VC_W-1:0]   w_g;
  logic [VC_W-1:0]   w_g_inc;
  logic              w_found;
  logic              w_has_g;
  logic              w_vld;
  logic              w_xfer;
  logic [FLIT_W-1:0] w_flit;
  logic [1:0]        w_type;

  // Round-robin scan starting at r_rr_ptr; falls back to r_gnt so vc_id_o is stable when idle.
  always_comb begin
    w_found = 1'b0;
    w_pick  = r_gnt;
    w_idx   = '0;
    for (int i = 0; i < N_VC; i++) begin
      w_idx = VC_W'((int'(r_rr_ptr) + i) % N_VC);
      if (!w_found && valid_i[w_idx]) begin
        w_found = 1'b1;
        w_pick  = w_idx;
      end
    end
  end

  assign w_has_g = (r_state != S_IDLE) || w_found;
  assign w_g     = (r_state == S_IDLE) ? w_pick : r_gnt;
  assign w_flit  = fdata_i[int'(w_g)*FLIT_W +: FLIT_W];
  assign w_type  = w_flit[FLIT_W-1 -: 2];
  assign w_vld   = !arst && w_has_g && valid_i[w_g];
  assign w_xfer  = w_vld && ready_i;
  assign w_g_inc = (int'(w_g) == N_VC-1) ? '0 : w_g + 1'b1;

  assign valid_o = w_vld;
  assign fdata_o = w_vld ? w_flit : '0;
  assign vc_id_o = arst ? '0 : w_g;
  assign busy_o  = (r_state != S_IDLE);
  assign err_o   = r_err;

  always_comb begin
    ready_o = '0;
    for (int k = 0; k < N_VC; k++) begin
      if (!arst && w_has_g && int'(w_g) == k) ready_o[k] = ready_i;
    end
  end

  always_ff @(posedge clk) begin
    if (arst) begin
      r_state  <= S_IDLE;
      r_gnt    <= '0;
      r_rr_ptr <= '0;
      r_err    <= 1'b0;
    end else begin
      r_err <= 1'b0;
      case (r_state)
        S_IDLE, S_HOLD: begin
          if (w_xfer) begin
            if (w_type == 2'b00) begin
              r_gnt   <= w_g;
              r_state <= S_LOCKED;
            end else begin
              // A lone body flit still closes the grant so the link cannot wedge.
              r_rr_ptr <= w_g_inc;
              r_state  <= S_IDLE;
              r_err    <= (w_type != 2'b11);
            end
          end else if (w_vld) begin
            r_gnt   <= w_g;
            r_state <= S_HOLD;
          end
        end
        S_LOCKED: begin
          if (w_xfer) begin
            if (w_type == 2'b11) begin
              r_rr_ptr <= w_g_inc;
              r_state  <= S_IDLE;
            end else if (w_type == 2'b00) begin
              r_err <= 1'b1;
            end
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end
endmodule
